// File: rtl/rf_pkg.sv
// Shared register-file constants.
// Used by the register, the register file and the write-back controller so
// that all of them agree on the architectural register count, the index
// width and the data width. LQ_DEPTH is the default load-queue depth of the
// write-back controller.
package rf_pkg;
  localparam int NREG     = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int LQ_DEPTH = 2;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding returned-load entries {rd, data}.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write wdata this cycle (ignored when full)
//   pop       : drop the head entry this cycle (ignored when empty)
//   wdata     : entry to enqueue
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : registered occupancy
//   head      : oldest entry (valid when !empty)
module wb_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller in front of the register file.
// Merges single-cycle ALU results with variable-latency load results into at
// most one register write per cycle, and tracks outstanding loads per
// register so decode can stall on hazards.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   alu_valid/rd/data     : ALU result; alu_stall (comb) refuses it when
//                           the destination has an outstanding load
//   issue_valid/issue_rd  : load issued to memory; marks rd busy
//   ld_valid/rd/data      : returned load beat; ld_ready accepts it
//   busy                  : per-register outstanding-load flags (registered)
//   we                    : one-hot register write enables (registered)
//   din                   : shared register write data (registered)
// Handshake: a load beat transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_ready depends only on registered occupancy and
// rst, never on ld_valid. The ALU side has no ready: alu_stall high means the
// presented result was not taken and must be held.
module wb_ctrl
  import rf_pkg::*;
#(
  parameter int NREG     = rf_pkg::NREG,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int LQ_DEPTH = rf_pkg::LQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [NREG-1:0]   busy,
  output logic [NREG-1:0]   we,
  output logic [DATA_W-1:0] din
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic              alu_acc;
  logic              lq_push;
  logic              lq_pop;
  logic              lq_full;
  logic              lq_empty;
  logic [CNT_W-1:0]  lq_count;
  logic [ENT_W-1:0]  lq_head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;

  function automatic logic [NREG-1:0] dec(input logic [ADDR_W-1:0] idx);
    dec      = '0;
    dec[idx] = 1'b1;
  endfunction

  assign alu_stall = alu_valid && busy[alu_rd];
  assign alu_acc   = alu_valid && !alu_stall;

  // A full queue refuses data even in a cycle where it dequeues, which keeps
  // ld_ready a pure function of registered state.
  assign ld_ready  = !rst && (lq_count < CNT_W'(LQ_DEPTH));
  assign lq_push   = ld_valid && ld_ready;
  // ALU writes have absolute priority; the queue drains only in gaps.
  assign lq_pop    = !rst && !alu_acc && !lq_empty;

  assign head_rd   = lq_head[ENT_W-1 -: ADDR_W];
  assign head_data = lq_head[DATA_W-1:0];

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .pop   (lq_pop),
    .wdata ({ld_rd, ld_data}),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count),
    .head  (lq_head)
  );

  // A load commit clears busy on the same edge that registers its we; a new
  // issue to the same register in that cycle wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) set_vec = dec(issue_rd);
    if (lq_pop)      clr_vec = dec(head_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we   <= '0;
      din  <= '0;
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
      if (alu_acc) begin
        we  <= dec(alu_rd);
        din <= alu_data;
      end else if (lq_pop) begin
        we  <= dec(head_rd);
        din <= head_data;
      end else begin
        we  <= '0;
      end
    end
  end

  // Illegal stimulus: re-issuing to a register whose load is still pending
  // (except in the cycle that load commits), a load returning to a register
  // with nothing outstanding, and pushing into a full queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (issue_valid) assert (!busy[issue_rd] || clr_vec[issue_rd]);
      if (lq_push)     assert (busy[ld_rd]);
      if (lq_push)     assert (!lq_full);
    end
  end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Write-back controller directly upstream of the register file's 16-bit registers. Merges single-cycle ALU results with variable-latency load results into one write per cycle. Drives the per-register write enables and shared write data. Tracks which registers have an outstanding load so decode can stall on hazards.

## Interface
Parameters:
- NREG, 8: number of architectural registers.
- ADDR_W, 3: register index width, equal to clog2(NREG).
- DATA_W, 16: data width.
- LQ_DEPTH, 2: load-result queue depth.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_stall  out  1  combinational; ALU write refused this cycle, so upstream must hold.
- issue_valid  in  1  load issued to memory this cycle.
- issue_rd  in  ADDR_W  load destination register.
- ld_valid  in  1  load data returned.
- ld_rd  in  ADDR_W  destination of the returned load.
- ld_data  in  DATA_W  returned load data.
- ld_ready  out  1  queue can accept a load; a transfer occurs when ld_valid and ld_ready are both high.
- busy  out  NREG  per-register outstanding-load flags (registered).
- we  out  NREG  one-hot register write enables (registered).
- din  out  DATA_W  write data to all registers (registered).

## Operation
- **Reset.** While rst is high at a clock edge: we = 0, din = 0, busy = 0, queue emptied. ld_ready is 0 while rst is high.
- **alu_stall** = alu_valid && busy[alu_rd].
- **ALU write.** An ALU write is accepted when alu_valid && !alu_stall. It has absolute priority over queued loads.
- **Load path.**
  - Each accepted load beat enqueues the pair {ld_rd, ld_data}.
  - ld_ready = (count < LQ_DEPTH), computed from the registered count only. A full queue does not accept data, even in a cycle where it dequeues.
  - The queue dequeues its head only in cycles with no accepted ALU write.
- **Commit.** Per cycle, at most one source commits: the accepted ALU write, else the queue head, else nothing. The commit registers we = one-hot(rd) and din = data. When nothing commits, we = 0 and din holds its last value.
- **Scoreboard.**
  - busy[issue_rd] is set when issue_valid is high.
  - busy[rd] is cleared on the edge that commits a load to rd.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- **Illegal stimulus (assertions only; behaviour undefined).**
  - issue_valid to a register that is already busy.
  - ld_valid for a register that is not busy.
- **Data-width rule.** DATA_W bits pass through unmodified. No sign or zero extension happens here.
- **Register 0.** r0 is an ordinary writable register; no special case.

## Timing
- **ALU latency.** ALU accepted in cycle N → we/din valid in cycle N+1 → the target register holds the data after the edge that ends cycle N+1.
- **Load latency, minimum.** Load accepted in cycle N, no ALU write in N+1 → dequeued in N+1 → we in N+2. There is no bypass around the queue.
- **Load delayed by ALU traffic.** Continuous ALU writes hold the queue. Once the queue is full, ld_ready deasserts the cycle after the second enqueue.
- **Busy release.** busy clears in the same cycle the load's we is visible. The earliest a previously stalled ALU write to that register can be accepted is the next cycle, where alu_stall = 0.
- **Ordering.** Queue order is FIFO. Loads commit in return order.
- **Reset mid-operation.** Queued loads are discarded, busy is cleared, and nothing is written in the reset cycle. An in-flight register write already presented on we completes as normal in the register.

## Structure
- Shared package `rf_pkg` holds NREG, ADDR_W and DATA_W, for common use by the register, the register file and this block.
- Sub-module `wb_fifo`:
  - parameterised synchronous FIFO of width ADDR_W + DATA_W and depth LQ_DEPTH;
  - ports: push, pop, full, empty, count, head.
- The top level holds the commit mux, the one-hot decode, the output registers and the scoreboard.

## Test plan
- **Reset:** rst high for 2 cycles with all inputs active → we = 0, din = 0x0000, busy = 0, ld_ready = 0; after release ld_ready = 1.
- **ALU write:** alu_valid with rd = 3, data = 0xBEEF in cycle N → we = 8'b0000_1000 and din = 0xBEEF in N+1; we = 0 in N+2.
- **Load path:**
  - stimulus: issue rd = 5; ld_valid in cycle N with data 0x1234;
  - response: busy[5] = 1 until the commit; we[5] = 1 with din = 0x1234 in N+2, and busy[5] = 0 in the same cycle.
- **Hazard stall:**
  - stimulus: busy[2] = 1, alu_valid with rd = 2;
  - response: alu_stall = 1 and no write; after the load to r2 commits, alu_stall = 0 and the ALU write lands the following cycle.
- **Backpressure:**
  - stimulus: continuous ALU writes while three loads (rd = 1, 4, 6) return back to back;
  - response: two are enqueued, ld_ready = 0 for the third; after the ALU stops, writes land to r1, r4, r6 in consecutive cycles.
- **Set/clear collision:** issue rd = 4 in the same cycle a load to r4 commits → busy[4] remains 1.
